// File: rtl/granule_stage_sequencer_pkg.sv
// Shared definitions for the granule stage sequencer: stage indices, FSM encoding
// and the default watchdog limit.
package granule_stage_sequencer_pkg;

    localparam int STAGE_HUFFMAN    = 0;
    localparam int STAGE_REQUANTIZE = 1;
    localparam int STAGE_REORDER    = 2;
    localparam int STAGE_STEREO     = 3;
    localparam int STAGE_ANTIALIAS  = 4;
    localparam int STAGE_IMDCT      = 5;

    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/granule_stage_sequencer_stage_watchdog.sv
// Per-stage watchdog: clearable saturating cycle counter with a registered
// one-cycle expiry pulse raised in the cycle the count reaches TIMEOUT_CYCLES.
module stage_watchdog
    import granule_stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;
    logic          expired_q, expired_d;

    // Saturates at the limit so a single expiry yields exactly one pulse.
    always_comb begin
        count_d   = count_q;
        expired_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(TIMEOUT_CYCLES))) begin
            count_d   = count_q + 1'b1;
            expired_d = (count_q == CW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/granule_stage_sequencer.sv
// Frame scheduler: pulses each decode stage in order, once per granule, waiting for
// each stage's done, and aborts the frame if a stage stalls past the watchdog limit.
module granule_stage_sequencer
    import granule_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES         = 6,
    parameter int GRANULES_PER_FRAME = 2,
    parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
    localparam int GW = (GRANULES_PER_FRAME > 1) ? $clog2(GRANULES_PER_FRAME) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [GW-1:0]         granule_index,
    output logic [3:0]            active_stage,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_error,
    output logic                  protocol_error
);

    seq_state_e            state_q, state_d;
    logic [NUM_STAGES-1:0] stage_ready_q, stage_ready_d;
    logic [GW-1:0]         granule_q, granule_d;
    logic [3:0]            active_q, active_d;
    logic                  frame_done_q, frame_done_d;
    logic                  perr_q, perr_d;

    logic                  in_wait;
    logic                  done_accept;
    logic                  last_stage;
    logic                  last_granule;
    logic                  expired;
    logic [NUM_STAGES-1:0] active_mask;
    logic [NUM_STAGES-1:0] stray_done;

    assign in_wait      = (state_q == ST_WAIT);
    assign active_mask  = NUM_STAGES'(1) << active_q;
    assign last_stage   = (active_q == 4'(NUM_STAGES - 1));
    assign last_granule = (granule_q == GW'(GRANULES_PER_FRAME - 1));
    // The cycle a stage is kicked its done is not yet meaningful.
    assign done_accept  = in_wait && !(|stage_ready_q) && |(stage_done & active_mask);

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stray
        assign stray_done[gi] = stage_done[gi] && (active_q != 4'(gi));
    end

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (|stage_ready_d),
        .enable (in_wait),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            stage_ready_q <= '0;
            granule_q     <= '0;
            active_q      <= '0;
            frame_done_q  <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_ready_q <= stage_ready_d;
            granule_q     <= granule_d;
            active_q      <= active_d;
            frame_done_q  <= frame_done_d;
            perr_q        <= perr_d;
        end
    end

    // A done that coincides with watchdog expiry takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_accept) begin
                    if (last_stage && last_granule) state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stage_ready_d = '0;
        frame_done_d  = 1'b0;
        granule_d     = granule_q;
        active_d      = active_q;
        perr_d        = perr_q | (in_wait && ((|stray_done) || frame_start));
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    granule_d     = '0;
                    active_d      = 4'(STAGE_HUFFMAN);
                    stage_ready_d = NUM_STAGES'(1);
                end
            end
            ST_WAIT: begin
                if (done_accept) begin
                    if (!last_stage) begin
                        active_d      = active_q + 4'd1;
                        stage_ready_d = active_mask << 1;
                    end else if (!last_granule) begin
                        granule_d     = granule_q + GW'(1);
                        active_d      = 4'(STAGE_HUFFMAN);
                        stage_ready_d = NUM_STAGES'(1);
                    end else begin
                        frame_done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign stage_ready    = stage_ready_q;
    assign granule_index  = granule_q;
    assign active_stage   = active_q;
    assign busy           = in_wait;
    assign frame_done     = frame_done_q;
    assign timeout_error  = (state_q == ST_ABORT);
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_granule_stage_sequencer.sv
// Randomized bench: a frame-level schedule model predicts every output per cycle.
module tb_granule_stage_sequencer;

    localparam int NS    = 3;
    localparam int NG    = 2;
    localparam int TO    = 16;
    localparam int STEPS = NS * NG;
    localparam int MAXC  = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_ready;
    logic [0:0]    granule_index;
    logic [3:0]    active_stage;
    logic          busy, frame_done, timeout_error, protocol_error;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    granule_stage_sequencer #(
        .NUM_STAGES(NS),
        .GRANULES_PER_FRAME(NG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .stage_ready(stage_ready),
        .stage_done(stage_done),
        .granule_index(granule_index),
        .active_stage(active_stage),
        .busy(busy),
        .frame_done(frame_done),
        .timeout_error(timeout_error),
        .protocol_error(protocol_error)
    );

    // Per-cycle expectations and stimulus, indexed by cycle within a scenario.
    logic [NS-1:0] exp_ready [MAXC];
    logic [NS-1:0] drv_done  [MAXC];
    logic [NS-1:0] extra_done[MAXC];
    bit            exp_busy  [MAXC];
    bit            exp_fd    [MAXC];
    bit            exp_to    [MAXC];
    bit            drv_start [MAXC];
    bit            extra_start[MAXC];
    bit            sched_rst [MAXC];
    int            exp_gran  [MAXC];
    int            exp_act   [MAXC];
    int            plan      [STEPS];   // done delay after ready per step; 0 = never answers
    bit            perr_exp = 1'b0;

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            exp_ready[c] = '0; drv_done[c] = '0; extra_done[c] = '0;
            exp_busy[c] = 1'b0; exp_fd[c] = 1'b0; exp_to[c] = 1'b0;
            drv_start[c] = 1'b0; extra_start[c] = 1'b0; sched_rst[c] = 1'b0;
            exp_gran[c] = 0; exp_act[c] = 0;
        end
    endtask

    task automatic set_plan(input int d);
        for (int k = 0; k < STEPS; k++) plan[k] = d;
    endtask

    // Frame started in cycle s: stage k's ready follows the previous done by one cycle.
    task automatic schedule_frame(input int s, output int end_c, output bit aborted);
        int r, g, st, d;
        drv_start[s] = 1'b1;
        r = s + 1;
        aborted = 1'b0;
        end_c = r;
        for (int k = 0; k < STEPS; k++) begin
            g = k / NS; st = k % NS; d = plan[k];
            exp_ready[r] = NS'(1) << st;
            if (d == 0) begin
                for (int c = r; c <= r + TO; c++) begin
                    exp_busy[c] = 1'b1; exp_gran[c] = g; exp_act[c] = st;
                end
                end_c = r + TO + 1;
                exp_to[end_c] = 1'b1;
                aborted = 1'b1;
                return;
            end
            for (int c = r; c <= r + d; c++) begin
                exp_busy[c] = 1'b1; exp_gran[c] = g; exp_act[c] = st;
            end
            drv_done[r + d] = drv_done[r + d] | (NS'(1) << st);
            if (k == STEPS - 1) begin
                end_c = r + d + 1;
                exp_fd[end_c] = 1'b1;
                return;
            end
            r = r + d + 1;
        end
    endtask

    task automatic execute(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            tests_run++;
            if (stage_ready !== exp_ready[c]) begin
                tests_failed++;
                $display("FAIL %s stage_ready cyc=%0d got=%b exp=%b", tag, c, stage_ready, exp_ready[c]);
            end
            tests_run++;
            if (busy !== exp_busy[c]) begin
                tests_failed++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, busy, exp_busy[c]);
            end
            tests_run++;
            if (frame_done !== exp_fd[c]) begin
                tests_failed++;
                $display("FAIL %s frame_done cyc=%0d got=%b exp=%b", tag, c, frame_done, exp_fd[c]);
            end
            tests_run++;
            if (timeout_error !== exp_to[c]) begin
                tests_failed++;
                $display("FAIL %s timeout_error cyc=%0d got=%b exp=%b", tag, c, timeout_error, exp_to[c]);
            end
            tests_run++;
            if (protocol_error !== perr_exp) begin
                tests_failed++;
                $display("FAIL %s protocol_error cyc=%0d got=%b exp=%b", tag, c, protocol_error, perr_exp);
            end
            if (exp_busy[c]) begin
                tests_run++;
                if (granule_index !== 1'(exp_gran[c]) || active_stage !== 4'(exp_act[c])) begin
                    tests_failed++;
                    $display("FAIL %s position cyc=%0d got=g%0d/s%0d exp=g%0d/s%0d",
                             tag, c, granule_index, active_stage, exp_gran[c], exp_act[c]);
                end
            end
            if (c > 0 && sched_rst[c-1]) begin
                tests_run++;
                if (granule_index !== 1'b0 || active_stage !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL %s post_reset_position cyc=%0d got=g%0d/s%0d exp=g0/s0",
                             tag, c, granule_index, active_stage);
                end
            end
            rst         = !sched_rst[c];
            frame_start = drv_start[c] | extra_start[c];
            stage_done  = drv_done[c] | extra_done[c];
            if (sched_rst[c])
                perr_exp = 1'b0;
            else if (exp_busy[c] && (extra_done[c] != '0 || extra_start[c]))
                perr_exp = 1'b1;
        end
        $display("[TB] scenario %s: %0d cycles checked", tag, ncyc);
    endtask

    task automatic test_reset();
        rst = 1'b0; frame_start = 1'b1; stage_done = '1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (stage_ready !== '0) begin tests_failed++; $display("FAIL reset stage_ready got=%b exp=0", stage_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy got=%b exp=0", busy); end
        tests_run++;
        if (granule_index !== 1'b0 || active_stage !== 4'd0) begin
            tests_failed++; $display("FAIL reset position got=g%0d/s%0d exp=g0/s0", granule_index, active_stage);
        end
        tests_run++;
        if (frame_done !== 1'b0 || timeout_error !== 1'b0) begin
            tests_failed++; $display("FAIL reset pulses got=fd%b/to%b exp=0/0", frame_done, timeout_error);
        end
        tests_run++;
        if (protocol_error !== 1'b0) begin tests_failed++; $display("FAIL reset protocol_error got=%b exp=0", protocol_error); end
        frame_start = 1'b0; stage_done = '0; rst = 1'b1;
        perr_exp = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_nominal();
        int e; bit a;
        clear_sched(); set_plan(5);
        schedule_frame(1, e, a);
        execute("nominal", e + 3);
    endtask

    task automatic test_back_to_back();
        int e1, e2; bit a;
        clear_sched(); set_plan(1);
        schedule_frame(1, e1, a);
        schedule_frame(e1, e2, a);
        execute("back_to_back", e2 + 3);
    endtask

    task automatic test_timeout();
        int e1, e2; bit a;
        clear_sched(); set_plan(3); plan[1] = 0;
        schedule_frame(1, e1, a);
        set_plan(3);
        schedule_frame(e1 + 2, e2, a);
        execute("timeout", e2 + 3);
    endtask

    task automatic test_race();
        int e; bit a;
        clear_sched(); set_plan(2); plan[2] = TO; plan[3] = TO;
        schedule_frame(1, e, a);
        execute("race", e + 3);
    endtask

    task automatic test_protocol();
        int e; bit a;
        clear_sched(); set_plan(5);
        schedule_frame(1, e, a);
        extra_done[3]   = 3'b100;   // stage 2 while stage 0 is pending
        extra_start[10] = 1'b1;     // frame_start mid-frame
        execute("protocol", e + 3);
    endtask

    task automatic test_reset_mid();
        int e; bit a;
        clear_sched(); set_plan(2);
        schedule_frame(1, e, a);    // granule 1 stage 1 becomes ready in cycle 14
        sched_rst[15] = 1'b1;
        for (int c = 16; c < MAXC; c++) begin
            exp_busy[c] = 1'b0; exp_ready[c] = '0; exp_fd[c] = 1'b0; exp_to[c] = 1'b0; drv_done[c] = '0;
        end
        extra_done[17] = 3'b010;    // late done from the abandoned frame
        execute("reset_mid", 24);
    endtask

    task automatic test_random();
        int s, e; bit a;
        clear_sched();
        s = 1; e = 1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < STEPS; k++)
                plan[k] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TO));
            schedule_frame(s, e, a);
            s = e + (a ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
        end
        execute("random", e + 3);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_race();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
